ripple_adder: RTL and testbench



---
 rtl/ripple_adder.sv | 90 +++++++++
 tb/tb_ripple_adder.sv | 136 +++++++++++++
 2 files changed

// File: rtl/ripple_adder.sv
// ripple_adder: WIDTH-bit ripple-carry adder built from a chain of full-adder
// cells, with the sum, carry-out (and optional overflow) registered for a
// fixed one-cycle latency. Synchronous active-high reset clears all outputs.
// Optional feature macro: RIPPLE_ADDER_OVF_EN adds a registered signed
// overflow output 'ovf'.

// Single-bit full adder cell, gate-level.
module ripple_adder_fa (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);
    logic p;

    assign p   = a_i ^ b_i;
    assign s_o = p ^ c_i;
    assign c_o = (a_i & b_i) | (c_i & p);
endmodule

module ripple_adder #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef RIPPLE_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);
    // c[i] is the carry into bit i; c[WIDTH] is the carry out of the MSB.
    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] sum_d;
    logic             cout_d;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;

    assign c[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        ripple_adder_fa u_fa (
            .a_i (a[i]),
            .b_i (b[i]),
            .c_i (c[i]),
            .s_o (sum_d[i]),
            .c_o (c[i+1])
        );
    end

    assign cout_d = c[WIDTH];

    // Result register: reset wins over new operands and drops the in-flight value.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;

`ifdef RIPPLE_ADDER_OVF_EN
    // Signed overflow: carries into and out of the sign bit disagree.
    logic ovf_d;
    logic ovf_q;

    assign ovf_d = c[WIDTH] ^ c[WIDTH-1];

    // Overflow register, same timing and reset as the sum.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif
endmodule

// File: tb/tb_ripple_adder.sv
// Scoreboard bench for ripple_adder (WIDTH=4): the driver pushes the expected
// registered result when it applies operands; the monitor pops one entry per
// cycle just after the rising edge and compares.
module tb_ripple_adder;
    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
`ifdef RIPPLE_ADDER_OVF_EN
    logic         ovf;
`endif

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        logic         chk_ovf;
        logic [15:0]  id;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   passes = 0;
    int   vec_id = 0;

    ripple_adder #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst  (rst),
        .a    (a),
        .b    (b),
        .cin  (cin),
        .sum  (sum),
`ifdef RIPPLE_ADDER_OVF_EN
        .ovf  (ovf),
`endif
        .cout (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one operand set on the falling edge and record its expected result.
    task automatic drive(input logic r, input logic [W-1:0] va, input logic [W-1:0] vb,
                         input logic vc, input logic [W-1:0] esum, input logic ecout,
                         input logic eovf, input logic chk_ovf);
        exp_t e;
        @(negedge clk);
        rst = r;
        a   = va;
        b   = vb;
        cin = vc;
        e.sum     = esum;
        e.cout    = ecout;
        e.ovf     = eovf;
        e.chk_ovf = chk_ovf;
        e.id      = 16'(vec_id);
        vec_id++;
        q.push_back(e);
    endtask

    // Monitor: each result is due exactly one edge after its operands.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if (sum === e.sum && cout === e.cout) passes++;
                else $display("FAIL sumcout vec %0d: got sum=%h cout=%b, want sum=%h cout=%b",
                              e.id, sum, cout, e.sum, e.cout);
`ifdef RIPPLE_ADDER_OVF_EN
                if (e.chk_ovf) begin
                    checks++;
                    if (ovf === e.ovf) passes++;
                    else $display("FAIL ovf vec %0d: got %b, want %b", e.id, ovf, e.ovf);
                end
`endif
            end
        end
    end

    initial begin
        logic [W:0]   tot;
        logic [W-1:0] ta;
        logic [W-1:0] tb;
        logic         eo;
        int           wait_cyc;

        rst = 1'b1; a = 4'hF; b = 4'hF; cin = 1'b1;
        // Reset held two cycles with busy operands: outputs stay 0.
        drive(1, 4'hF, 4'hF, 1, 4'h0, 0, 0, 1);
        drive(1, 4'hF, 4'hF, 1, 4'h0, 0, 0, 1);
        // Directed vectors, back-to-back, hand-computed results.
        drive(0, 4'b0101, 4'b1010, 0, 4'b1111, 0, 0, 1);
        drive(0, 4'b0000, 4'b1011, 0, 4'b1011, 0, 0, 1);
        drive(0, 4'b1111, 4'b0001, 0, 4'b0000, 1, 0, 1);
        drive(0, 4'hF,    4'hF,    1, 4'hF,    1, 0, 1);
        drive(0, 4'h0,    4'h0,    1, 4'h1,    0, 0, 1);
        drive(0, 4'b0111, 4'b0001, 0, 4'b1000, 0, 1, 1);
        drive(0, 4'b1000, 4'b1111, 0, 4'b0111, 1, 1, 1);
        drive(0, 4'b0011, 4'b0010, 0, 4'b0101, 0, 0, 1);
        drive(0, 4'h6,    4'h9,    1, 4'h0,    1, 0, 1);
        // Reset mid-stream discards the in-flight operands.
        drive(1, 4'h7,    4'h9,    1, 4'h0,    0, 0, 1);
        drive(0, 4'h3,    4'h4,    0, 4'h7,    0, 0, 1);
        drive(0, 4'hC,    4'h5,    1, 4'h2,    1, 0, 1);
        // Exhaustive sweep of all 512 operand combinations.
        for (int i = 0; i < 512; i++) begin
            ta  = 4'(i >> 5);
            tb  = 4'(i >> 1);
            tot = {1'b0, ta} + {1'b0, tb} + 5'(i & 1);
            eo  = (ta[W-1] == tb[W-1]) && (tot[W-1] != ta[W-1]);
            drive(0, ta, tb, 1'(i & 1), tot[W-1:0], tot[W], eo, 1);
        end
        // Drain the scoreboard, bounded.
        wait_cyc = 0;
        while (q.size() > 0 && wait_cyc < 10) begin
            @(posedge clk);
            wait_cyc++;
        end
        @(negedge clk);
        if (q.size() > 0) begin
            checks++;
            $display("FAIL drain: %0d results outstanding, want 0", q.size());
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
